// File: rtl/reset_sequencer.sv
// Ordered release of active-low peripheral resets with a ready watchdog.
// Re-sequences on watchdog expiry, then latches FAULT after MAX_RETRIES.
module reset_sequencer #(
  parameter int NUM_STAGES = 2,
  parameter int CNT_W = 23,
  parameter logic [NUM_STAGES*CNT_W-1:0] DELAYS =
    {CNT_W'(6000000), CNT_W'(300000)},
  parameter int HOLD_CYCLES = 3000,
  parameter int TIMEOUT = 3000000,
  parameter int MAX_RETRIES = 3,
  localparam int RW =
    (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  retrigger_i,
  input  logic                  ready_i,
  output logic [NUM_STAGES-1:0] stage_rst_n_o,
  output logic                  done_o,
  output logic                  fault_o,
  output logic [RW-1:0]         retry_cnt_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_COUNT = 3'd1,
    S_WAIT  = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] D_LAST =
    DELAYS[(NUM_STAGES-1)*CNT_W +: CNT_W];
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [RW-1:0] RET_MAX = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RET_ONE = RW'(1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_STAGES-1:0] r_stage;
  logic [RW-1:0]         r_retry;
  logic                  r_done;
  logic                  r_fault;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [NUM_STAGES-1:0] w_stage_nxt;
  logic [NUM_STAGES-1:0] w_stage_due;
  logic [RW-1:0]         w_retry_nxt;

  // Which stages have reached their release delay at the current count
  always_comb begin
    w_stage_due = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_stage_due[i] = (r_cnt >= DELAYS[i*CNT_W +: CNT_W]);
    end
  end

  // Next-state, counter, stage and retry decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_retry_nxt = r_retry;
    if (retrigger_i) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
      if (r_state == S_FAULT) begin
        w_retry_nxt = '0;
      end
    end else begin
      unique case (r_state)
        S_HOLD: begin
          w_stage_nxt = '0;
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = S_COUNT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        S_COUNT: begin
          w_stage_nxt = r_stage | w_stage_due;
          if (r_cnt >= D_LAST) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        S_WAIT: begin
          if (ready_i) begin
            w_state_nxt = S_RUN;
          end else if (TO_EN) begin
            if (r_cnt == TO_LAST) begin
              if (r_retry < RET_MAX) begin
                w_retry_nxt = r_retry + RET_ONE;
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = '0;
                w_stage_nxt = '0;
              end else begin
                w_state_nxt = S_FAULT;
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end
        end
        S_RUN: begin
          w_state_nxt = S_RUN;
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_stage <= '0;
      r_retry <= '0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
      r_retry <= w_retry_nxt;
      r_done  <= (w_state_nxt == S_RUN);
      r_fault <= (w_state_nxt == S_FAULT);
    end
  end

  assign stage_rst_n_o = r_stage;
  assign done_o        = r_done;
  assign fault_o       = r_fault;
  assign retry_cnt_o   = r_retry;
  assign state_o       = r_state;

endmodule
